ahb_slv_resp_mux: RTL
=====================

Name: ahb_slv_resp_mux

Overview:
Parametrised slave-to-master response multiplexer for the generated AHB interconnect; successor to the one-hot combinational slave mux. It registers the address-phase slave select into the data phase, gated by bus HREADY, and forwards the selected slave's {hreadyout, hresp, hrdata} response. It embeds an AHB default slave that returns a two-cycle ERROR response for active transfers to unmapped or multi-hot selects, and keeps a saturating decode-error counter. One instance sits per master port, behind the decoder.

Parameters:
CHANNEL_NUM, 3, number of slave response channels (>=1)
DATA_WIDTH, 32, HRDATA width; payload width is DATA_WIDTH+2
CNT_W, 8, decode-error counter width

Ports:
hclk  in  1  bus clock
hreset  in  1  asynchronous, active-high reset
sel_addr  in  CHANNEL_NUM  address-phase one-hot slave select from decoder
htrans  in  2  address-phase HTRANS (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
hready  in  1  bus-level HREADY (fed back from hreadyout_o)
payload_in  in  CHANNEL_NUM x (DATA_WIDTH+2)  per slave {hreadyout, hresp, hrdata}, MSB first
hrdata_o  out  DATA_WIDTH  muxed read data
hresp_o  out  1  muxed HRESP (0 OKAY, 1 ERROR)
hreadyout_o  out  1  muxed HREADYOUT
dp_sel_o  out  CHANNEL_NUM  registered data-phase select
err_cnt_o  out  CNT_W  decode-error count
err_cnt_clr  in  1  synchronous clear of err_cnt_o

Behaviour:
- Reset (async, on hreset=1): dp_sel=0, dflt_state=IDLE, err_cnt=0. Outputs show default-slave OKAY: hreadyout_o=1, hresp_o=0, hrdata_o=0.
- Address-to-data latch: on rising hclk with hready=1, dp_sel <= sel_addr if sel_addr is exactly one-hot, else 0. With hready=0, dp_sel holds.
- Unmapped condition (unmap_a): sel_addr is zero or multi-hot, and htrans is NONSEQ or SEQ, sampled with hready=1.
- Output mux is combinational on dp_sel:
  - One-hot dp_sel forwards payload_in[i] unchanged. This is zero added latency.
  - dp_sel=0 forwards the default-slave response.
- Default-slave FSM states:
  - IDLE: drives {1,OKAY,0}. Goes to ERR1 on unmap_a; otherwise stays.
  - ERR1: drives {hreadyout=0, hresp=1, hrdata=0}. Always goes to ERR2 next cycle.
  - ERR2: drives {hreadyout=1, hresp=1, hrdata=0}. Goes to ERR1 on unmap_a (back-to-back error); otherwise IDLE.
  - An address phase of IDLE/BUSY to an unmapped select gets a zero-wait OKAY; the FSM stays in IDLE.
- Error counter: err_cnt increments by 1 on each IDLE/ERR2 -> ERR1 transition. It saturates at 2^CNT_W-1 and never wraps.
  - err_cnt_clr=1 forces 0 and has priority over a simultaneous increment.
- Simultaneous events: in ERR1 hready=0 by construction, so no new address phase is accepted. A mapped transfer sampled in ERR2 loads dp_sel and returns the FSM to IDLE in the same edge.
- Reset mid-transfer: any state returns to IDLE and dp_sel clears immediately. No ERROR is left pending.
- X-safety: with dp_sel=0, payload_in is ignored entirely.

Decomposition:
- AHB_package holds:
  - HTRANS constants (HTRANS_IDLE/BUSY/NONSEQ/SEQ).
  - HRESP_OKAY/HRESP_ERROR.
  - A parameterless response struct typedef {hreadyout, hresp, hrdata[31:0]} for the default width.
  - A function onehot_chk(vector) returning valid one-hot.
- Natural sub-module: ahb_default_slave. It contains the FSM plus err_cnt, takes unmap_a/hready, and outputs the response triple. The mux and dp_sel register stay in the top.

Test Plan:
- Reset check: assert hreset with clock running -> hreadyout_o=1, hresp_o=0, hrdata_o=0, dp_sel_o=0, err_cnt_o=0.
- Mapped read: sel_addr=3'b010, htrans=NONSEQ, hready=1, slave1 payload {1,0,32'hDEADBEEF} -> next cycle dp_sel_o=3'b010 and hrdata_o=32'hDEADBEEF, hresp_o=0.
- Wait states: slave2 selected and driving hreadyout=0 for 3 cycles, with a new sel_addr=3'b001 presented -> dp_sel_o stays 3'b100 until hready=1, then becomes 3'b001.
- Unmapped NONSEQ (sel_addr=0): ERR1 cycle hreadyout_o=0, hresp_o=1; ERR2 cycle hreadyout_o=1, hresp_o=1; then IDLE; err_cnt_o=1.
- Multi-hot sel_addr=3'b011 with SEQ in ERR2 -> back-to-back ERR1/ERR2, err_cnt_o=2.
  - Unmapped with htrans=IDLE -> single OKAY cycle, err_cnt unchanged.
- Saturation/clear: CNT_W=2, 5 errors -> err_cnt_o=3. Then err_cnt_clr=1 coincident with an error increment -> err_cnt_o=0.
  - hreset pulsed during ERR1 -> IDLE, hreadyout_o=1 immediately.

Source files
------------

// File: rtl/ahb_slv_resp_mux_pkg.sv
// -----------------------------------------------------------------------------
// ahb_slv_resp_mux_pkg
// Shared AHB definitions for the slave response multiplexer:
//   - HTRANS encodings and HRESP encodings
//   - ahb_resp_t : response triple {hreadyout, hresp, hrdata} at the default
//                  32-bit data width
//   - onehot_chk : true when a select vector has exactly one bit set
// -----------------------------------------------------------------------------
package ahb_slv_resp_mux_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Widest select vector onehot_chk accepts; callers zero-extend into it.
  localparam int ONEHOT_MAX = 32;

  typedef struct packed {
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
  } ahb_resp_t;

  // A vector is one-hot when it is non-zero and clearing its lowest set bit
  // leaves nothing behind.
  function automatic logic onehot_chk(input logic [ONEHOT_MAX-1:0] vec);
    logic [ONEHOT_MAX-1:0] one;
    one = {{(ONEHOT_MAX-1){1'b0}}, 1'b1};
    return (vec != '0) && ((vec & (vec - one)) == '0);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// -----------------------------------------------------------------------------
// ahb_default_slave
// AHB default slave answering transfers that the decoder could not map to a
// single slave. An active transfer to such a select gets the two-cycle ERROR
// response (ERR1: wait + ERROR, ERR2: ready + ERROR). Also counts decode
// errors in a saturating counter with synchronous clear.
//
// Ports:
//   hclk, hreset   bus clock, asynchronous active-high reset
//   unmap_a        address phase is active (NONSEQ/SEQ) with a zero or
//                  multi-hot select; qualified here with hready
//   hready         bus-level HREADY
//   err_cnt_clr    synchronous clear of the error counter (wins over +1)
//   hreadyout_o    default-slave HREADYOUT
//   hresp_o        default-slave HRESP
//   hrdata_o       default-slave HRDATA (always zero)
//   err_cnt_o      decode-error count
// -----------------------------------------------------------------------------
module ahb_default_slave
  import ahb_slv_resp_mux_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 8
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  unmap_a,
  input  logic                  hready,
  input  logic                  err_cnt_clr,
  output logic                  hreadyout_o,
  output logic                  hresp_o,
  output logic [DATA_WIDTH-1:0] hrdata_o,
  output logic [CNT_W-1:0]      err_cnt_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ERR1 = 2'd1;
  localparam logic [1:0] ST_ERR2 = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             go_err;
  logic             err_inc;

  // A new address phase is only accepted while the bus is ready.
  assign go_err = unmap_a & hready;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (go_err) state_d = ST_ERR1;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = go_err ? ST_ERR1 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Entering ERR1 from IDLE or ERR2 marks one new decode error.
  assign err_inc = (state_q != ST_ERR1) && (state_d == ST_ERR1);

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_cnt_clr) begin
      err_cnt_d = '0;
    end else if (err_inc && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of block evaluation order.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q   <= ST_IDLE;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    hreadyout_o = 1'b1;
    hresp_o     = HRESP_OKAY;
    unique case (state_q)
      ST_ERR1: begin
        hreadyout_o = 1'b0;
        hresp_o     = HRESP_ERROR;
      end
      ST_ERR2: begin
        hreadyout_o = 1'b1;
        hresp_o     = HRESP_ERROR;
      end
      default: begin
        hreadyout_o = 1'b1;
        hresp_o     = HRESP_OKAY;
      end
    endcase
  end

  assign hrdata_o  = '0;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: rtl/ahb_slv_resp_mux.sv
// -----------------------------------------------------------------------------
// ahb_slv_resp_mux
// Slave-to-master response multiplexer, one per master port. The decoder's
// address-phase one-hot select is registered into the data phase while
// HREADY is high; the registered select picks one slave's
// {hreadyout, hresp, hrdata} with no added latency. A zero or multi-hot
// select routes to the embedded default slave (OKAY, or a two-cycle ERROR
// for active transfers). CHANNEL_NUM must be between 1 and 32.
//
// Ports:
//   hclk, hreset   bus clock, asynchronous active-high reset
//   sel_addr       address-phase one-hot slave select
//   htrans         address-phase HTRANS
//   hready         bus-level HREADY (fed back from hreadyout_o)
//   payload_in     per-slave {hreadyout, hresp, hrdata}, slave i at bits
//                  [i*(DATA_WIDTH+2) +: DATA_WIDTH+2]
//   hrdata_o       muxed read data
//   hresp_o        muxed HRESP
//   hreadyout_o    muxed HREADYOUT
//   dp_sel_o       registered data-phase select
//   err_cnt_o      decode-error count
//   err_cnt_clr    synchronous clear of err_cnt_o
// -----------------------------------------------------------------------------
module ahb_slv_resp_mux
  import ahb_slv_resp_mux_pkg::*;
#(
  parameter int CHANNEL_NUM = 3,
  parameter int DATA_WIDTH  = 32,
  parameter int CNT_W       = 8
) (
  input  logic                                    hclk,
  input  logic                                    hreset,
  input  logic [CHANNEL_NUM-1:0]                  sel_addr,
  input  logic [1:0]                              htrans,
  input  logic                                    hready,
  input  logic [CHANNEL_NUM*(DATA_WIDTH+2)-1:0]   payload_in,
  output logic [DATA_WIDTH-1:0]                   hrdata_o,
  output logic                                    hresp_o,
  output logic                                    hreadyout_o,
  output logic [CHANNEL_NUM-1:0]                  dp_sel_o,
  output logic [CNT_W-1:0]                        err_cnt_o,
  input  logic                                    err_cnt_clr
);

  localparam int PW = DATA_WIDTH + 2;

  logic [CHANNEL_NUM-1:0] dp_sel_q, dp_sel_d;
  logic [ONEHOT_MAX-1:0]  sel_ext;
  logic                   sel_onehot;
  logic                   trans_active;
  logic                   unmap_a;

  logic                   dflt_hreadyout;
  logic                   dflt_hresp;
  logic [DATA_WIDTH-1:0]  dflt_hrdata;

  assign sel_ext      = ONEHOT_MAX'(sel_addr);
  assign sel_onehot   = onehot_chk(sel_ext);
  assign trans_active = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);

  // Address-phase condition only; the default slave qualifies it with hready.
  assign unmap_a = trans_active & ~sel_onehot;

  // An invalid select is stored as zero so the data phase falls through to
  // the default slave instead of OR-ing several slaves together.
  always_comb begin
    dp_sel_d = dp_sel_q;
    if (hready) begin
      dp_sel_d = sel_onehot ? sel_addr : '0;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      dp_sel_q <= '0;
    end else begin
      dp_sel_q <= dp_sel_d;
    end
  end

  ahb_default_slave #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_dflt (
    .hclk        (hclk),
    .hreset      (hreset),
    .unmap_a     (unmap_a),
    .hready      (hready),
    .err_cnt_clr (err_cnt_clr),
    .hreadyout_o (dflt_hreadyout),
    .hresp_o     (dflt_hresp),
    .hrdata_o    (dflt_hrdata),
    .err_cnt_o   (err_cnt_o)
  );

  // dp_sel_q is zero or one-hot, so at most one branch below fires; with zero
  // the payload bus is never looked at.
  always_comb begin
    hreadyout_o = dflt_hreadyout;
    hresp_o     = dflt_hresp;
    hrdata_o    = dflt_hrdata;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      if (dp_sel_q[i]) begin
        {hreadyout_o, hresp_o, hrdata_o} = payload_in[i*PW +: PW];
      end
    end
  end

  assign dp_sel_o = dp_sel_q;

endmodule
